// File: rtl/fifo_tx_drain.sv
// ---------------------------------------------------------------------------
// fifo_tx_drain
//
// Read-domain bridge between an asynchronous FIFO read port and a UART
// transmitter. Pops one word at a time, presents it as a one-cycle start
// pulse, then follows the transmitter's busy handshake to completion before
// popping again. Adds an optional inter-frame gap, a busy-timeout retry that
// re-sends the held word, and a wrapping completed-frame counter.
// Everything runs on the FIFO read clock.
//
// Parameters
//   DATA_WIDTH    width of FIFO read data / UART parallel data
//   GAP_CYCLES    idle cycles after each completed frame (0 = none)
//   BUSY_TIMEOUT  cycles to wait for TX_BUSY after a start pulse (0 = forever)
//   CNT_WIDTH     width of FRAME_CNT
//
// Ports
//   R_CLK          in   read-domain clock
//   R_RST          in   asynchronous active-low reset
//   EN             in   drain enable; only gates new pops
//   R_EMPTY        in   FIFO empty flag
//   RD_DATA        in   FIFO read data at the current read address
//   R_INC          out  FIFO pop strobe (combinational, IDLE only)
//   TX_BUSY        in   UART transmitter busy
//   TX_P_DATA      out  registered word being transmitted
//   TX_DATA_VALID  out  one-cycle start pulse to the transmitter
//   DRAIN_BUSY     out  high whenever the FSM is not idle
//   FRAME_CNT      out  completed frames, wraps
//   TIMEOUT_ERR    out  sticky busy-timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module fifo_tx_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int GAP_CYCLES   = 0,
  parameter int BUSY_TIMEOUT = 255,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic                  EN,
  input  logic                  R_EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  R_INC,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_DATA_VALID,
  output logic                  DRAIN_BUSY,
  output logic [CNT_WIDTH-1:0]  FRAME_CNT,
  output logic                  TIMEOUT_ERR
);

  // One timer serves both the gap and the busy-wait, so it is sized for the
  // larger of the two.
  localparam int MAX_WAIT = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
  localparam int TMR_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [TMR_W-1:0] TO_END   = TMR_W'(BUSY_TIMEOUT);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VALID,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t                r_state;
  logic [TMR_W-1:0]      r_tmr;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_valid;
  logic                  r_drain_busy;
  logic [CNT_WIDTH-1:0]  r_frame_cnt;
  logic                  r_timeout_err;

  logic                  w_pop;

  // The pop strobe is combinational so the FIFO sees it in the same cycle the
  // decision is made. It is qualified with reset so it stays low while reset
  // is held, even though IDLE is the reset state.
  assign w_pop = R_RST && (r_state == S_IDLE) && EN && !R_EMPTY && !TX_BUSY;

  assign R_INC         = w_pop;
  assign TX_P_DATA     = r_tx_data;
  assign TX_DATA_VALID = r_tx_valid;
  assign DRAIN_BUSY    = r_drain_busy;
  assign FRAME_CNT     = r_frame_cnt;
  assign TIMEOUT_ERR   = r_timeout_err;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every branch below reads the pre-edge value of every register.
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      r_state       <= S_IDLE;
      r_tmr         <= '0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_drain_busy  <= 1'b0;
      r_frame_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      // Start pulse is high only for the single cycle spent in VALID.
      r_tx_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_tx_data    <= RD_DATA;
            r_tx_valid   <= 1'b1;
            r_drain_busy <= 1'b1;
            r_state      <= S_VALID;
          end
        end

        S_VALID: begin
          r_tmr   <= '0;
          r_state <= S_WAIT_BUSY;
        end

        S_WAIT_BUSY: begin
          if (TX_BUSY) begin
            r_state <= S_WAIT_DONE;
          end else if (BUSY_TIMEOUT != 0) begin
            if (r_tmr == TO_END) begin
              // Flag went up on the previous edge; now re-send the held word
              // without popping.
              r_tx_valid <= 1'b1;
              r_state    <= S_VALID;
            end else begin
              r_tmr <= r_tmr + 1'b1;
              if (r_tmr == TO_LAST) begin
                r_timeout_err <= 1'b1;
              end
            end
          end
        end

        S_WAIT_DONE: begin
          if (!TX_BUSY) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
            if (GAP_CYCLES != 0) begin
              r_tmr   <= '0;
              r_state <= S_GAP;
            end else begin
              r_drain_busy <= 1'b0;
              r_state      <= S_IDLE;
            end
          end
        end

        S_GAP: begin
          if (r_tmr == GAP_LAST) begin
            r_drain_busy <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end

        default: begin
          r_drain_busy <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_tx_drain.sv
// ---------------------------------------------------------------------------
// tb_fifo_tx_drain
//
// Two instances: dut_a (no gap, BUSY_TIMEOUT=4) and dut_g (GAP_CYCLES=3,
// wait forever). Each has a FIFO model, a UART TX model (busy one cycle after
// an accepted start pulse, for TX_LEN cycles) and a scoreboard: the word at
// the FIFO head is pushed when R_INC is seen, and every TX_DATA_VALID is
// compared against the oldest outstanding word. Monitors sample on the
// falling edge; models drive 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_fifo_tx_drain;

  localparam int TX_LEN = 10;
  localparam int TO     = 4;
  localparam int GAP    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- instance A: GAP_CYCLES=0, BUSY_TIMEOUT=4 ----------------
  logic        a_rst_n = 1'b0, a_en = 1'b0, a_empty = 1'b1, a_busy = 1'b0;
  logic [7:0]  a_rd = '0;
  logic        a_inc, a_valid, a_dbusy, a_terr;
  logic [7:0]  a_txd;
  logic [15:0] a_cnt;

  fifo_tx_drain #(.DATA_WIDTH(8), .GAP_CYCLES(0), .BUSY_TIMEOUT(TO), .CNT_WIDTH(16)) dut_a (
    .R_CLK(clk), .R_RST(a_rst_n), .EN(a_en), .R_EMPTY(a_empty), .RD_DATA(a_rd),
    .R_INC(a_inc), .TX_BUSY(a_busy), .TX_P_DATA(a_txd), .TX_DATA_VALID(a_valid),
    .DRAIN_BUSY(a_dbusy), .FRAME_CNT(a_cnt), .TIMEOUT_ERR(a_terr)
  );

  // ---------------- instance G: GAP_CYCLES=3, BUSY_TIMEOUT=0 ----------------
  logic        g_rst_n = 1'b0, g_en = 1'b0, g_empty = 1'b1, g_busy = 1'b0;
  logic [7:0]  g_rd = '0;
  logic        g_inc, g_valid, g_dbusy, g_terr;
  logic [7:0]  g_txd;
  logic [15:0] g_cnt;

  fifo_tx_drain #(.DATA_WIDTH(8), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(0), .CNT_WIDTH(16)) dut_g (
    .R_CLK(clk), .R_RST(g_rst_n), .EN(g_en), .R_EMPTY(g_empty), .RD_DATA(g_rd),
    .R_INC(g_inc), .TX_BUSY(g_busy), .TX_P_DATA(g_txd), .TX_DATA_VALID(g_valid),
    .DRAIN_BUSY(g_dbusy), .FRAME_CNT(g_cnt), .TIMEOUT_ERR(g_terr)
  );

  // ---------------- model state ----------------
  logic [7:0] a_fifo[$], a_exp[$], g_fifo[$], g_exp[$];
  int a_inc_t[$], a_valid_t[$], a_fall_t[$], g_inc_t[$];
  int a_cyc = 0, g_cyc = 0;
  int a_bcnt = 0, g_bcnt = 0;
  int a_ignore = 0;
  int a_terr_t = -1;
  int a_spacing = 0;
  bit a_inc_s = 1'b0, a_valid_s = 1'b0, g_inc_s = 1'b0, g_valid_s = 1'b0;

  // Monitors / scoreboards (falling edge)
  always @(negedge clk) begin
    a_cyc++;
    a_inc_s   = a_inc;
    a_valid_s = a_valid;
    if (a_inc === 1'b1) begin
      a_inc_t.push_back(a_cyc);
      if (a_fifo.size() > 0) a_exp.push_back(a_fifo[0]);
      checks++;
      if (a_dbusy !== 1'b0) begin
        failures++;
        $display("FAIL a_pop_while_busy: DRAIN_BUSY=%b required 0", a_dbusy);
      end
    end
    if (a_valid === 1'b1) begin
      a_valid_t.push_back(a_cyc);
      checks++;
      if (a_exp.size() == 0) begin
        failures++;
        $display("FAIL a_sb_valid: TX_P_DATA=%h but no word outstanding", a_txd);
      end else if (a_txd !== a_exp[0]) begin
        failures++;
        $display("FAIL a_sb_data: TX_P_DATA=%h required %h", a_txd, a_exp[0]);
      end
    end
    if (a_terr === 1'b1 && a_terr_t < 0) a_terr_t = a_cyc;
  end

  always @(negedge clk) begin
    g_cyc++;
    g_inc_s   = g_inc;
    g_valid_s = g_valid;
    if (g_inc === 1'b1) begin
      g_inc_t.push_back(g_cyc);
      if (g_fifo.size() > 0) g_exp.push_back(g_fifo[0]);
    end
    if (g_valid === 1'b1) begin
      checks++;
      if (g_exp.size() == 0) begin
        failures++;
        $display("FAIL g_sb_valid: TX_P_DATA=%h but no word outstanding", g_txd);
      end else if (g_txd !== g_exp[0]) begin
        failures++;
        $display("FAIL g_sb_data: TX_P_DATA=%h required %h", g_txd, g_exp[0]);
      end
    end
  end

  // FIFO + TX models (just after the rising edge)
  always @(posedge clk) begin
    #1;
    if (a_inc_s && a_fifo.size() > 0) void'(a_fifo.pop_front());
    a_empty = (a_fifo.size() == 0);
    a_rd    = (a_fifo.size() > 0) ? a_fifo[0] : 8'h00;
    if (a_bcnt > 0) begin
      a_bcnt--;
      if (a_bcnt == 0) begin
        a_busy = 1'b0;
        a_fall_t.push_back(a_cyc + 1);
      end
    end
    if (a_valid_s) begin
      if (a_ignore > 0) a_ignore--;
      else begin
        a_busy = 1'b1;
        a_bcnt = TX_LEN;
        if (a_exp.size() > 0) void'(a_exp.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (g_inc_s && g_fifo.size() > 0) void'(g_fifo.pop_front());
    g_empty = (g_fifo.size() == 0);
    g_rd    = (g_fifo.size() > 0) ? g_fifo[0] : 8'h00;
    if (g_bcnt > 0) begin
      g_bcnt--;
      if (g_bcnt == 0) g_busy = 1'b0;
    end
    if (g_valid_s) begin
      g_busy = 1'b1;
      g_bcnt = TX_LEN;
      if (g_exp.size() > 0) void'(g_exp.pop_front());
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic reset_a();
    a_rst_n = 1'b0;
    a_en    = 1'b0;
    a_fifo.delete();
    a_exp.delete();
    a_busy = 1'b0; a_bcnt = 0; a_ignore = 0;
    tick(2);
    a_rst_n = 1'b1;
    tick(1);
    a_inc_t.delete(); a_valid_t.delete(); a_fall_t.delete(); a_terr_t = -1;
  endtask

  task automatic reset_g();
    g_rst_n = 1'b0;
    g_en    = 1'b0;
    g_fifo.delete();
    g_exp.delete();
    g_busy = 1'b0; g_bcnt = 0;
    tick(2);
    g_rst_n = 1'b1;
    tick(1);
    g_inc_t.delete();
  endtask

  task automatic wait_a(input int frames, input int budget, input string what);
    int n = 0;
    while (!(a_cnt === 16'(frames) && a_dbusy === 1'b0) && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_wait: FRAME_CNT=%0d DRAIN_BUSY=%b, required %0d and 0 within %0d cycles",
               what, a_cnt, a_dbusy, frames, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    a_rst_n = 1'b0; g_rst_n = 1'b0;
    tick(3);
    checks++; if (a_inc   !== 1'b0)  begin failures++; $display("FAIL rst_inc: got %b required 0", a_inc); end
    checks++; if (a_txd   !== 8'h00) begin failures++; $display("FAIL rst_txd: got %h required 00", a_txd); end
    checks++; if (a_valid !== 1'b0)  begin failures++; $display("FAIL rst_valid: got %b required 0", a_valid); end
    checks++; if (a_dbusy !== 1'b0)  begin failures++; $display("FAIL rst_dbusy: got %b required 0", a_dbusy); end
    checks++; if (a_cnt   !== 16'h0) begin failures++; $display("FAIL rst_cnt: got %0d required 0", a_cnt); end
    checks++; if (a_terr  !== 1'b0)  begin failures++; $display("FAIL rst_terr: got %b required 0", a_terr); end
    checks++;
    if ({g_inc, g_valid, g_dbusy, g_terr, g_txd, g_cnt} !== 28'h0) begin
      failures++;
      $display("FAIL rst_g: outputs=%h required 0", {g_inc, g_valid, g_dbusy, g_terr, g_txd, g_cnt});
    end
    a_rst_n = 1'b1; g_rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_single();
    reset_a();
    a_fifo.push_back(8'hA5);
    a_en = 1'b1;
    wait_a(1, 100, "single");
    checks++; if (a_inc_t.size() != 1)   begin failures++; $display("FAIL single_pops: got %0d required 1", a_inc_t.size()); end
    checks++; if (a_valid_t.size() != 1) begin failures++; $display("FAIL single_valids: got %0d required 1", a_valid_t.size()); end
    if (a_inc_t.size() > 0 && a_valid_t.size() > 0) begin
      checks++;
      if (a_valid_t[0] - a_inc_t[0] != 1) begin
        failures++;
        $display("FAIL single_latency: valid %0d cycles after pop, required 1", a_valid_t[0] - a_inc_t[0]);
      end
    end
    checks++; if (a_txd !== 8'hA5)     begin failures++; $display("FAIL single_txd: got %h required a5", a_txd); end
    checks++; if (a_cnt !== 16'd1)     begin failures++; $display("FAIL single_cnt: got %0d required 1", a_cnt); end
    checks++; if (a_fifo.size() != 0)  begin failures++; $display("FAIL single_fifo: %0d left required 0", a_fifo.size()); end
    checks++; if (a_dbusy !== 1'b0)    begin failures++; $display("FAIL single_dbusy: got %b required 0", a_dbusy); end
  endtask

  task automatic test_back_to_back();
    reset_a();
    for (int i = 1; i <= 4; i++) a_fifo.push_back(8'(i));
    a_en = 1'b1;
    wait_a(4, 300, "b2b");
    checks++; if (a_cnt !== 16'd4)     begin failures++; $display("FAIL b2b_cnt: got %0d required 4", a_cnt); end
    checks++; if (a_inc_t.size() != 4) begin failures++; $display("FAIL b2b_pops: got %0d required 4", a_inc_t.size()); end
    if (a_inc_t.size() == 4 && a_fall_t.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (a_inc_t[k+1] != a_fall_t[k] + 1) begin
          failures++;
          $display("FAIL b2b_next_pop%0d: pop at %0d, required %0d", k, a_inc_t[k+1], a_fall_t[k] + 1);
        end
      end
      a_spacing = a_inc_t[1] - a_inc_t[0];
      checks++;
      if (a_spacing != TX_LEN + 3) begin
        failures++;
        $display("FAIL b2b_spacing: got %0d required %0d", a_spacing, TX_LEN + 3);
      end
    end
  endtask

  task automatic test_gap();
    int n = 0;
    reset_g();
    g_fifo.push_back(8'h5A);
    g_fifo.push_back(8'hC3);
    g_en = 1'b1;
    while (!(g_cnt === 16'd2 && g_dbusy === 1'b0) && n < 300) begin tick(1); n++; end
    checks++; if (n >= 300) begin failures++; $display("FAIL gap_wait: FRAME_CNT=%0d required 2", g_cnt); end
    checks++; if (g_inc_t.size() != 2) begin failures++; $display("FAIL gap_pops: got %0d required 2", g_inc_t.size()); end
    if (g_inc_t.size() == 2) begin
      checks++;
      if (g_inc_t[1] - g_inc_t[0] != a_spacing + GAP) begin
        failures++;
        $display("FAIL gap_spacing: got %0d required %0d", g_inc_t[1] - g_inc_t[0], a_spacing + GAP);
      end
    end
  endtask

  task automatic test_timeout();
    reset_a();
    a_ignore = 1;
    a_fifo.push_back(8'h3C);
    a_en = 1'b1;
    wait_a(1, 300, "timeout");
    checks++; if (a_terr !== 1'b1)       begin failures++; $display("FAIL to_err: got %b required 1", a_terr); end
    checks++; if (a_inc_t.size() != 1)   begin failures++; $display("FAIL to_pops: got %0d required 1", a_inc_t.size()); end
    checks++; if (a_valid_t.size() != 2) begin failures++; $display("FAIL to_valids: got %0d required 2", a_valid_t.size()); end
    if (a_valid_t.size() == 2) begin
      checks++;
      if (a_terr_t != a_valid_t[0] + TO + 1) begin
        failures++;
        $display("FAIL to_err_time: rose at +%0d required +%0d", a_terr_t - a_valid_t[0], TO + 1);
      end
      checks++;
      if (a_valid_t[1] != a_valid_t[0] + TO + 2) begin
        failures++;
        $display("FAIL to_retry_time: retry at +%0d required +%0d", a_valid_t[1] - a_valid_t[0], TO + 2);
      end
    end
    checks++; if (a_cnt !== 16'd1) begin failures++; $display("FAIL to_cnt: got %0d required 1", a_cnt); end
    tick(5);
    checks++; if (a_terr !== 1'b1) begin failures++; $display("FAIL to_sticky: got %b required 1", a_terr); end
  endtask

  task automatic test_en_drop();
    int n = 0;
    reset_a();
    a_fifo.push_back(8'hAA);
    a_fifo.push_back(8'hBB);
    a_fifo.push_back(8'hCC);
    a_en = 1'b1;
    while (a_busy !== 1'b1 && n < 50) begin tick(1); n++; end
    checks++; if (n >= 50) begin failures++; $display("FAIL en_busy_wait: TX never went busy"); end
    tick(2);
    a_en = 1'b0;
    wait_a(1, 100, "en_drop");
    tick(20);
    checks++; if (a_cnt !== 16'd1)     begin failures++; $display("FAIL en_cnt: got %0d required 1", a_cnt); end
    checks++; if (a_inc_t.size() != 1) begin failures++; $display("FAIL en_pops: got %0d required 1", a_inc_t.size()); end
    checks++; if (a_txd !== 8'hAA)     begin failures++; $display("FAIL en_txd: got %h required aa", a_txd); end
    checks++; if (a_fifo.size() != 2)  begin failures++; $display("FAIL en_fifo: %0d left required 2", a_fifo.size()); end
    a_en = 1'b1;
    wait_a(3, 300, "en_resume");
    checks++; if (a_inc_t.size() != 3) begin failures++; $display("FAIL en_resume_pops: got %0d required 3", a_inc_t.size()); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    reset_a();
    a_ignore = 1000;
    a_fifo.push_back(8'h11);
    a_fifo.push_back(8'h22);
    a_en = 1'b1;
    while (a_valid_t.size() == 0 && n < 50) begin tick(1); n++; end
    checks++; if (n >= 50) begin failures++; $display("FAIL rm_valid_wait: no start pulse"); end
    a_rst_n = 1'b0;
    #1;
    checks++;
    if ({a_inc, a_valid, a_dbusy, a_terr, a_txd, a_cnt} !== 28'h0) begin
      failures++;
      $display("FAIL rm_outputs: inc=%b valid=%b dbusy=%b terr=%b txd=%h cnt=%0d required all 0",
               a_inc, a_valid, a_dbusy, a_terr, a_txd, a_cnt);
    end
    a_exp.delete(); a_ignore = 0; a_busy = 1'b0; a_bcnt = 0;
    tick(2);
    a_inc_t.delete(); a_valid_t.delete();
    a_rst_n = 1'b1;
    wait_a(1, 100, "rm_resume");
    checks++; if (a_inc_t.size() != 1) begin failures++; $display("FAIL rm_pops: got %0d required 1", a_inc_t.size()); end
    checks++; if (a_txd !== 8'h22)     begin failures++; $display("FAIL rm_txd: got %h required 22", a_txd); end
    checks++; if (a_cnt !== 16'd1)     begin failures++; $display("FAIL rm_cnt: got %0d required 1", a_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_timeout();
    test_en_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_tx_drain.md
# fifo_tx_drain

Read-domain bridge between the asynchronous FIFO read side and the UART transmitter. It watches the FIFO empty flag, pops one word at a time, and presents each word to the UART TX as a single-cycle valid pulse. It then tracks the transmitter's busy handshake to completion before popping again, with an optional inter-frame gap, busy-timeout retry and frame counter. It runs entirely in the FIFO read clock domain.

## Interface
- DATA_WIDTH, 8, width of FIFO read data and UART TX parallel data
- GAP_CYCLES, 0, idle cycles inserted after each completed frame (0 = none)
- BUSY_TIMEOUT, 255, cycles to wait for TX_BUSY to rise after a valid pulse (0 = wait forever)
- CNT_WIDTH, 16, width of FRAME_CNT

- R_CLK  input  1  read-domain clock; the only clock
- R_RST  input  1  asynchronous, active-low reset
- EN  input  1  drain enable; gates new pops only
- R_EMPTY  input  1  FIFO empty flag (read domain)
- RD_DATA  input  DATA_WIDTH  FIFO read data at current read address, combinational
- R_INC  output  1  FIFO pop strobe
- TX_BUSY  input  1  UART TX busy
- TX_P_DATA  output  DATA_WIDTH  registered byte to transmit
- TX_DATA_VALID  output  1  one-cycle start pulse to UART TX
- DRAIN_BUSY  output  1  high in any state other than IDLE
- FRAME_CNT  output  CNT_WIDTH  completed frames, wraps modulo 2^CNT_WIDTH
- TIMEOUT_ERR  output  1  sticky; set on any busy timeout, cleared only by reset

## Operation
- States: IDLE, VALID, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - Pop condition: EN=1 and R_EMPTY=0 and TX_BUSY=0.
  - R_INC is combinational and equals the pop condition while in IDLE; it is 0 in every other state.
  - On a pop edge, RD_DATA is latched into TX_P_DATA and the state moves to VALID.
- VALID: TX_DATA_VALID=1 for exactly this one cycle, then WAIT_BUSY. The timeout counter clears.
- WAIT_BUSY:
  - TX_BUSY=1 → WAIT_DONE.
  - If BUSY_TIMEOUT≠0 and the counter reaches BUSY_TIMEOUT with TX_BUSY still 0: set TIMEOUT_ERR, return to VALID, and re-send the same TX_P_DATA. There is no pop and no retry limit.
- WAIT_DONE:
  - TX_BUSY=0 → FRAME_CNT+1.
  - Next state is GAP if GAP_CYCLES>0, else IDLE.
- GAP: counts GAP_CYCLES cycles, then IDLE. No pop occurs during GAP.
- Exactly one R_INC per frame. A word is never popped while another is held.
- EN deasserted mid-frame: the current frame completes normally; only the next pop is blocked.
- EN=0 in IDLE with data pending: no R_INC and no output change.
- TX_BUSY=1 while in IDLE (the transmitter is in use by another source): no pop until it drops.
- Counter width: $clog2(max(GAP_CYCLES, BUSY_TIMEOUT)+1), minimum 1. A single counter is shared by GAP and WAIT_BUSY.
- Reset mid-operation:
  - The state returns to IDLE and all outputs go to reset values.
  - An already-popped, unsent byte is lost; this is accepted behaviour.

## Timing
- Reset values: R_INC=0, TX_P_DATA=0, TX_DATA_VALID=0, DRAIN_BUSY=0, FRAME_CNT=0, TIMEOUT_ERR=0, state=IDLE.
- Pop at cycle N (R_INC=1) → TX_DATA_VALID=1 at N+1 → earliest WAIT_DONE entry at N+3 (TX_BUSY sampled high at N+2).
- R_EMPTY updates one cycle after the pop. The FSM is in VALID then, so a stale R_EMPTY is never acted on.
- TX_BUSY sampled low in WAIT_DONE at edge M: FRAME_CNT updates at M. With GAP_CYCLES=0, the next R_INC can occur in cycle M+1.
- With GAP_CYCLES=G, the earliest next R_INC is G cycles later than the G=0 case.
- Timeout: TIMEOUT_ERR rises BUSY_TIMEOUT+1 cycles after the VALID cycle. The retried TX_DATA_VALID follows one cycle later.
- TX_P_DATA is stable from the cycle after the pop until the next pop.

## Test plan
- Reset, FIFO holding 0xA5, EN=1, TX model asserts busy 1 cycle after valid for 10 cycles:
  - exactly one R_INC, TX_P_DATA=0xA5, one TX_DATA_VALID pulse one cycle after R_INC;
  - FRAME_CNT=1, FIFO then empty, DRAIN_BUSY=0.
- FIFO preloaded 0x01..0x04, GAP_CYCLES=0: four frames in order, FRAME_CNT=4, no R_INC while DRAIN_BUSY=1, next R_INC one cycle after busy falls.
- GAP_CYCLES=3, two bytes: the second R_INC is exactly 3 cycles later than in the GAP_CYCLES=0 run.
- BUSY_TIMEOUT=4, TX model ignores the first valid:
  - TIMEOUT_ERR=1, second TX_DATA_VALID with the same byte, still only one R_INC;
  - FRAME_CNT=1 after the model responds; TIMEOUT_ERR stays 1.
- EN dropped during WAIT_DONE with 3 bytes queued: current frame completes (FRAME_CNT+1), no further R_INC until EN=1.
- R_RST asserted in WAIT_BUSY: all outputs are 0 immediately; after release, the next queued byte is popped normally.
